// File: rtl/store_unit.sv
// store_unit: store-path lane alignment and memory write handshake.
// Places store data on byte lanes of a word-aligned 32-bit write port,
// generates byte strobes and issues the write over valid/ready.
// Optional feature macro: STORE_SPLIT_EN -- when defined, a store that
// crosses a word boundary is issued as two beats; when undefined such a
// store is rejected with an err pulse.
module store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            store_mode,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              base_mask;
  logic [31:0]             data_masked;
  logic                    mode_legal;
  logic [7:0]              strb8;
  logic                    crossing;
  logic [4:0]              shamt;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [31:0]             lo_wdata;

`ifdef STORE_SPLIT_EN
  logic [63:0]             wide64;
  logic                    split_pend;
  logic [31:0]             hi_wdata;
  logic [3:0]              hi_strb;
`endif

  assign req_ready = (state == IDLE);

  // Width decode and lane math for the incoming request.
  always_comb begin
    base_mask   = '0;
    data_masked = '0;
    mode_legal  = 1'b0;
    case (store_mode)
      3'b000: begin
        base_mask   = 4'b0001;
        data_masked = {24'b0, req_data[7:0]};
        mode_legal  = 1'b1;
      end
      3'b001: begin
        base_mask   = 4'b0011;
        data_masked = {16'b0, req_data[15:0]};
        mode_legal  = 1'b1;
      end
      3'b010: begin
        base_mask   = 4'b1111;
        data_masked = req_data;
        mode_legal  = 1'b1;
      end
      default: ;
    endcase
    strb8     = {4'b0000, base_mask} << req_addr[1:0];
    crossing  = |strb8[7:4];
    shamt     = {req_addr[1:0], 3'b000};
    word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef STORE_SPLIT_EN
    wide64    = {32'b0, data_masked} << shamt;
    lo_wdata  = wide64[31:0];
`else
    // Only the low word of the shifted data is ever needed here.
    lo_wdata  = data_masked << shamt;
`endif
  end

  // Control FSM with registered beat payload and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef STORE_SPLIT_EN
      split_pend <= 1'b0;
      hi_wdata   <= '0;
      hi_strb    <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!mode_legal) begin
              err <= 1'b1;
`ifndef STORE_SPLIT_EN
            end else if (crossing) begin
              err <= 1'b1;
`endif
            end else begin
              mem_valid <= 1'b1;
              mem_addr  <= word_addr;
              mem_wdata <= lo_wdata;
              mem_wstrb <= strb8[3:0];
`ifdef STORE_SPLIT_EN
              split_pend <= crossing;
              hi_wdata   <= wide64[63:32];
              hi_strb    <= strb8[7:4];
`endif
              state <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
`ifdef STORE_SPLIT_EN
            if (split_pend) begin
              mem_addr  <= mem_addr + ADDR_WIDTH'(4);
              mem_wdata <= hi_wdata;
              mem_wstrb <= hi_strb;
              state     <= BEAT1;
            end else begin
              mem_valid <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              done      <= 1'b1;
              state     <= IDLE;
            end
`else
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            done      <= 1'b1;
            state     <= IDLE;
`endif
          end
        end
`ifdef STORE_SPLIT_EN
        BEAT1: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            split_pend <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: byte-level reference model plus directed vectors.
// Works for both builds (STORE_SPLIT_EN defined or not).
module tb_store_unit;

  localparam int AW = 32;
`ifdef STORE_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [2:0]    store_mode;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          done;
  logic          err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .store_mode (store_mode),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } beat_t;

  beat_t scratch[$];
  beat_t q[$];
  bit    m_done = 1'b0;
  bit    m_err  = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference: walk the stored bytes one by one, grouping them by memory word.
  function automatic bit plan(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] mode);
    int          n;
    int          lane;
    logic [31:0] a;
    logic [31:0] w;
    beat_t       cur;
    bit          have;
    scratch.delete();
    case (mode)
      3'b000:  n = 1;
      3'b001:  n = 2;
      3'b010:  n = 4;
      default: n = 0;
    endcase
    if (n == 0) return 1'b0;
    have = 1'b0;
    cur.addr = '0; cur.wdata = '0; cur.strb = '0;
    for (int k = 0; k < n; k++) begin
      a    = addr + 32'(k);
      w    = {a[31:2], 2'b00};
      lane = int'(a[1:0]);
      if (!have || cur.addr != w) begin
        if (have) scratch.push_back(cur);
        cur.addr = w; cur.wdata = '0; cur.strb = '0;
        have = 1'b1;
      end
      cur.wdata[8*lane +: 8] = data[8*k +: 8];
      cur.strb[lane] = 1'b1;
    end
    scratch.push_back(cur);
    if (scratch.size() > 1 && !SPLIT) begin
      scratch.delete();
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Model: a pending list of beats, drained one per memory handshake.
  always @(posedge clk or negedge rst_n) begin
    bit idle;
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      idle   = (q.size() == 0);
      m_done = 1'b0;
      m_err  = 1'b0;
      if (idle) begin
        if (req_valid) begin
          if (plan(req_addr, req_data, store_mode)) q = scratch;
          else m_err = 1'b1;
        end
      end else if (mem_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, q.size() > 0});
    chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() == 0});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (q.size() > 0) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wdata", mem_wdata, q[0].wdata);
      chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, q[0].strb});
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    int unsigned waited = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("send_ready", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_data   = d;
    store_mode = m;
    @(posedge clk); #2;
    req_valid  = 1'b0;
  endtask

  task automatic beat_is(input string name, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    chk({name, "_valid"}, {31'b0, mem_valid}, 32'd1);
    chk({name, "_addr"}, mem_addr, a);
    chk({name, "_wdata"}, mem_wdata, d);
    chk({name, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, s});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    store_mode = 3'b000; mem_ready = 1'b1;
    #1;
    // Pin the reference model with hand-computed values.
    ok = plan(32'h1003, 32'hAABBCCDD, 3'b000);
    chk("pin_sb_ok", {31'b0, ok}, 32'd1);
    chk("pin_sb_n", scratch.size(), 32'd1);
    chk("pin_sb_addr", scratch[0].addr, 32'h1000);
    chk("pin_sb_wdata", scratch[0].wdata, 32'hDD000000);
    chk("pin_sb_strb", {28'b0, scratch[0].strb}, 32'h8);
    ok = plan(32'h2002, 32'hFFFF1234, 3'b001);
    chk("pin_sh_wdata", scratch[0].wdata, 32'h12340000);
    ok = plan(32'h3001, 32'h11223344, 3'b010);
    chk("pin_sw_ok", {31'b0, ok}, {31'b0, SPLIT});
    if (SPLIT) begin
      chk("pin_sw_b0", scratch[0].wdata, 32'h22334400);
      chk("pin_sw_b1a", scratch[1].addr, 32'h3004);
      chk("pin_sw_b1d", scratch[1].wdata, 32'h00000011);
    end
    ok = plan(32'h4000, 32'h0, 3'b011);
    chk("pin_illegal", {31'b0, ok}, 32'd0);

    // Reset values.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #2;

    // SB into the top lane.
    send(32'h1003, 32'hAABBCCDD, 3'b000);
    beat_is("sb", 32'h1000, 32'hDD000000, 4'b1000);
    @(posedge clk); #2;
    chk("sb_done", {31'b0, done}, 32'd1);
    chk("sb_ready", {31'b0, req_ready}, 32'd1);

    // SH into the upper half.
    send(32'h2002, 32'hFFFF1234, 3'b001);
    beat_is("sh", 32'h2000, 32'h12340000, 4'b1100);
    @(posedge clk); #2;
    chk("sh_done", {31'b0, done}, 32'd1);

    // Misaligned SW crossing a word.
    send(32'h3001, 32'h11223344, 3'b010);
    if (SPLIT) begin
      beat_is("sw_b0", 32'h3000, 32'h22334400, 4'b1110);
      @(posedge clk); #2;
      beat_is("sw_b1", 32'h3004, 32'h00000011, 4'b0001);
      chk("sw_mid_done", {31'b0, done}, 32'd0);
      @(posedge clk); #2;
      chk("sw_done", {31'b0, done}, 32'd1);
    end else begin
      chk("sw_nv", {31'b0, mem_valid}, 32'd0);
      chk("sw_err", {31'b0, err}, 32'd1);
      chk("sw_nodone", {31'b0, done}, 32'd0);
      @(posedge clk); #2;
      chk("sw_err_clr", {31'b0, err}, 32'd0);
    end

    // Crossing at the top of the address space wraps to zero.
    send(32'hFFFFFFFE, 32'h11223344, 3'b010);
    if (SPLIT) begin
      beat_is("wrap_b0", 32'hFFFFFFFC, 32'h33440000, 4'b1100);
      @(posedge clk); #2;
      beat_is("wrap_b1", 32'h00000000, 32'h00001122, 4'b0011);
      @(posedge clk); #2;
      chk("wrap_done", {31'b0, done}, 32'd1);
    end else begin
      chk("wrap_err", {31'b0, err}, 32'd1);
      @(posedge clk); #2;
    end

    // Memory stall: payload holds, no done until handshake.
    mem_ready = 1'b0;
    send(32'h2002, 32'hFFFF1234, 3'b001);
    for (int i = 0; i < 3; i++) begin
      beat_is("stall", 32'h2000, 32'h12340000, 4'b1100);
      chk("stall_ready", {31'b0, req_ready}, 32'd0);
      chk("stall_done", {31'b0, done}, 32'd0);
      @(posedge clk); #2;
    end
    mem_ready = 1'b1;
    @(posedge clk); #2;
    chk("stall_done_end", {31'b0, done}, 32'd1);
    // Back-to-back: new request during the done cycle.
    send(32'h1003, 32'hAABBCCDD, 3'b000);
    beat_is("b2b", 32'h1000, 32'hDD000000, 4'b1000);
    @(posedge clk); #2;
    chk("b2b_done", {31'b0, done}, 32'd1);

    // Illegal mode, then an immediate legal request.
    send(32'h4000, 32'h12345678, 3'b011);
    chk("ill_err", {31'b0, err}, 32'd1);
    chk("ill_nv", {31'b0, mem_valid}, 32'd0);
    chk("ill_nodone", {31'b0, done}, 32'd0);
    send(32'h5001, 32'h000000A5, 3'b000);
    chk("ill_err_clr", {31'b0, err}, 32'd0);
    beat_is("after_ill", 32'h5000, 32'h0000A500, 4'b0010);
    @(posedge clk); #2;
    chk("after_ill_done", {31'b0, done}, 32'd1);

    // Reset while a beat is pending.
    mem_ready = 1'b0;
    if (SPLIT) begin
      send(32'h3001, 32'h11223344, 3'b010);
      mem_ready = 1'b1;
      @(posedge clk); #2;
      mem_ready = 1'b0;
      beat_is("pre_rst_b1", 32'h3004, 32'h00000011, 4'b0001);
    end else begin
      send(32'h2002, 32'hFFFF1234, 3'b001);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, mem_valid}, 32'd0);
    chk("mrst_done", {31'b0, done}, 32'd0);
    chk("mrst_err", {31'b0, err}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("mrst_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #2;
    send(32'h1003, 32'hAABBCCDD, 3'b000);
    beat_is("post_rst", 32'h1000, 32'hDD000000, 4'b1000);
    @(posedge clk); #2;
    chk("post_rst_done", {31'b0, done}, 32'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Store-path counterpart to the load extension logic. Accepts a store request (address, rs2 data, funct3 width code), places the data on the correct byte lanes of a word-aligned 32-bit memory write port, generates byte strobes, and drives the write over a valid/ready handshake. Sits between the execute stage and data memory. A store that crosses a word boundary is split into two beats when split support is compiled in.

## Interface
- ADDR_WIDTH, 32: byte-address width; the data path is fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_WIDTH  byte address.
- req_data  in  32  store data; low bits are used per width.
- store_mode  in  3  funct3: SB=000, SH=001, SW=010; all other codes are illegal.
- mem_valid  out  1  write beat present.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-aligned data; unstrobed lanes are 0.
- mem_wstrb  out  4  byte enables; bit i maps to wdata[8i+7:8i].
- done  out  1  one-cycle pulse after the final beat handshake.
- err  out  1  one-cycle pulse for an illegal mode or a rejected misaligned store.

## Operation
- States: IDLE, BEAT0, BEAT1.
- Accept: `req_valid && req_ready` at edge T; address, data and mode are registered.
- Lane math:
  - off = req_addr[1:0].
  - base mask: SB=0001, SH=0011, SW=1111, each zero-extended to 8 bits.
  - strb8 = mask << off.
  - wide64 = {32'b0, req_data masked to width} << (8*off).
- Beat0 payload:
  - mem_addr = req_addr with [1:0] cleared.
  - mem_wdata = wide64[31:0].
  - mem_wstrb = strb8[3:0].
- Crossing: strb8[7:4] != 0.
  - Beat1 payload: mem_addr = beat0 address + 4, wrapping modulo 2^ADDR_WIDTH.
  - mem_wdata = wide64[63:32].
  - mem_wstrb = strb8[7:4].
- Legal, non-crossing store: IDLE -> BEAT0. On handshake -> IDLE, done=1 next cycle.
- Legal, crossing store (macro defined): IDLE -> BEAT0. On handshake -> BEAT1. On handshake -> IDLE, done next cycle.
- Illegal mode: accepted; state stays IDLE; no beat issued; err=1 at T+1; done stays 0.
- In BEAT0/BEAT1, mem_valid holds high and mem_addr/mem_wdata/mem_wstrb hold stable until mem_ready is seen.
- done and err are never high in the same cycle.

## Timing
- Reset values (immediate on rst_n low): state=IDLE; req_ready=1 once rst_n is high; mem_valid=0; mem_addr, mem_wdata, mem_wstrb = 0; done=0; err=0.
- Outputs are registered. Accept at edge T gives mem_valid high from T+1.
- mem_ready high at T+1 gives single-beat completion: done high during T+2, with req_ready high.
- Minimum latency: single beat, accept to done = 2 cycles; two beats = 3 cycles.
- A new request may be accepted in the same cycle done is high (back-to-back).
- mem_ready while mem_valid is low is ignored.
- Reset mid-operation drops the in-flight beat. A split store interrupted after beat0 leaves a partial write; this is accepted behaviour, with no recovery.

## Configuration
- STORE_SPLIT_EN defined: crossing stores issue two beats as described above.
- STORE_SPLIT_EN undefined:
  - A crossing store is accepted and no beat is issued.
  - err pulses at T+1 and state stays IDLE.
  - BEAT1 logic is absent.
  - Non-crossing stores behave identically in both builds.

## Test plan
- SB, addr 0x1003, data 0xAABBCCDD -> one beat: addr 0x1000, wdata 0xDD000000, wstrb 1000, done 2 cycles after accept.
- SH, addr 0x2002, data 0xFFFF1234 -> one beat: addr 0x2000, wdata 0x12340000, wstrb 1100.
- SW, addr 0x3001, data 0x11223344:
  - with STORE_SPLIT_EN: beat0 = 0x3000 / 0x22334400 / 1110, then beat1 = 0x3004 / 0x00000011 / 0001, then done.
  - without STORE_SPLIT_EN: mem_valid stays 0 and err pulses.
- SW, addr 0xFFFFFFFE (split build) -> beat1 addr 0x00000000, wstrb 0011. Separately, hold mem_ready low 3 cycles on any beat: payload stable throughout, req_ready=0, done only after the handshake.
- store_mode 011 -> no beat, err=1 for one cycle, done=0; a request presented the next cycle is accepted.
- Assert rst_n low while the BEAT1 beat is pending -> mem_valid, done, err are 0 immediately; after release, req_ready=1 and a fresh SB completes normally.
